// File: rtl/sub_pkg.sv
// Package: sub_pkg
// Shared constants and types for nibble_serial_subtractor.
//   NIB_W   : width of one serial slice pass (4 bits)
//   state_t : controller state encoding
package sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub4_slice.sv
// Module: sub4_slice
// Combinational 4-bit borrow-ripple subtractor: d4 = a4 - b4 - bi.
// Ports:
//   a4 [3:0] in  : minuend nibble
//   b4 [3:0] in  : subtrahend nibble
//   bi       in  : borrow-in
//   d4 [3:0] out : difference nibble
//   bo       out : borrow-out of the nibble
module sub4_slice
  import sub_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             bi,
  output logic [NIB_W-1:0] d4,
  output logic             bo
);

  logic brw;

  always_comb begin
    brw = bi;
    d4  = '0;
    for (int i = 0; i < NIB_W; i++) begin
      d4[i] = a4[i] ^ b4[i] ^ brw;
      // Borrow when a<b at this bit, or a==b and a borrow is already pending.
      brw   = (~a4[i] & b4[i]) | (~(a4[i] ^ b4[i]) & brw);
    end
    bo = brw;
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Module: nibble_serial_subtractor
// Multi-cycle WIDTH-bit subtractor, d = a - b - bin, one nibble per clock,
// LSB nibble first, using a single 4-bit borrow-ripple slice whose borrow-out
// is registered into the next pass. WIDTH must be a multiple of 4 (>= 4).
// Optional feature macro: SIGNED_OVF_EN adds the ovf output (signed overflow).
// Ports:
//   clk            in  : system clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   start          in  : request, sampled only in IDLE
//   a, b [WIDTH]   in  : minuend / subtrahend, captured on accepted start
//   bin            in  : borrow-in to nibble 0, captured on accepted start
//   busy           out : high while in RUN
//   done           out : one-cycle pulse, result valid
//   d [WIDTH]      out : difference, held until the next done
//   bout           out : borrow-out of the MSB nibble, held with d
//   ovf            out : signed overflow, held with d (SIGNED_OVF_EN only)
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one slice pass per cycle, NIBBLES cycles
// DONE  | result registered, done pulse; returns to IDLE
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_w_q, a_w_d;
  logic [WIDTH-1:0] b_w_q, b_w_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
`ifdef SIGNED_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0] slice_d;
  logic             slice_bo;
  logic [WIDTH-1:0] work_shift;

  sub4_slice u_slice (
    .a4 (a_w_q[NIB_W-1:0]),
    .b4 (b_w_q[NIB_W-1:0]),
    .bi (brw_q),
    .d4 (slice_d),
    .bo (slice_bo)
  );

  // New difference nibble enters at the MSB end; after NIBBLES passes the
  // first nibble has drifted down to bit 0. The cast keeps WIDTH==4 legal.
  assign work_shift = (work_q >> NIB_W) | (WIDTH'(slice_d) << (WIDTH - NIB_W));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_w_d   = a_w_q;
    b_w_d   = b_w_q;
    brw_d   = brw_q;
    work_d  = work_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SIGNED_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_w_d   = a;
          b_w_d   = b;
          brw_d   = bin;
          work_d  = '0;
`ifdef SIGNED_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_w_d  = a_w_q >> NIB_W;
        b_w_d  = b_w_q >> NIB_W;
        brw_d  = slice_bo;
        cnt_d  = cnt_q + CNT_W'(1);
        work_d = work_shift;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          d_d     = work_shift;
          bout_d  = slice_bo;
`ifdef SIGNED_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (work_shift[WIDTH-1] != a_msb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_w_q   <= '0;
      b_w_q   <= '0;
      brw_q   <= 1'b0;
      work_q  <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_w_q   <= a_w_d;
      b_w_q   <= b_w_d;
      brw_q   <= brw_d;
      work_q  <= work_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SIGNED_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] d;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] prev_d = '0;
  logic         prev_bout = 1'b0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge and push the model result.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
    exp_t e;
    logic [W:0] r;
    r      = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
    e.d    = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    sb.push_back(e);
    a = av; b = bv; bin = binv; start = 1'b1;
  endtask

  // Wait for done (bounded), counting busy cycles; clears start after the
  // first edge. While busy, the previously reported result must stay put.
  task automatic wait_done(output int lat, output int nbusy);
    exp_t e;
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        nbusy++;
        check("d_held_run", 32'(d), 32'(prev_d));
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check("done_seen", 32'(lat != 0), 32'd1);
    if (lat != 0) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("d", 32'(d), 32'(e.d));
        check("bout", 32'(bout), 32'(e.bout));
`ifdef SIGNED_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        prev_d = e.d;
        prev_bout = e.bout;
      end
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat, nbusy, nd;
    logic [W-1:0] ra, rb;
    logic         rbin;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic case with latency/busy-length check.
    issue(16'h1234, 16'h0234, 1'b0);
    wait_done(lat, nbusy);
    check("latency", 32'(lat), 32'd5);
    check("busy_cycles", 32'(nbusy), 32'd4);
    @(negedge clk);
    check("done_pulse_one", 32'(done), 32'd0);

    // Borrow chains through every nibble.
    issue(16'h0000, 16'h0001, 1'b0);
    wait_done(lat, nbusy);
    @(negedge clk);
    issue(16'h0005, 16'h0005, 1'b1);
    wait_done(lat, nbusy);
    @(negedge clk);
    issue(16'h8000, 16'h0001, 1'b0);
    wait_done(lat, nbusy);
    @(negedge clk);

    // Start during RUN must be ignored; latched operands unaffected.
    issue(16'h1234, 16'h0234, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
    wait_done(lat, nbusy);
    check("ign_latency", 32'(lat), 32'd3);
    count_dones(12, nd);
    check("ign_single_done", 32'(nd), 32'd0);
    check("ign_d_kept", 32'(d), 32'h1000);

    // Asynchronous reset in the second RUN cycle.
    issue(16'h1234, 16'h0234, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_d", 32'(d), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    sb.delete();
    prev_d = '0; prev_bout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(8, nd);
    check("rst_no_done", 32'(nd), 32'd0);
    issue(16'h0010, 16'h0001, 1'b0);
    wait_done(lat, nbusy);
    check("post_rst_d", 32'(d), 32'h000F);

    // Random back-to-back operations.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = '0; rb = 16'hFFFF; rbin = 1'b1; end
      if (i == 1) begin ra = 16'hFFFF; rb = '0; rbin = 1'b0; end
      issue(ra, rb, rbin);
      wait_done(lat, nbusy);
      if (lat != 5) check("rand_latency", 32'(lat), 32'd5);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
